// File: rtl/inst_fetch_stage_pkg.sv
// inst_fetch_stage_pkg: shared widths and constants for the fetch stage.
package inst_fetch_stage_pkg;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
endpackage

// File: rtl/inst_fetch_stage_fetch_hold_buf.sv
// fetch_hold_buf: captures the response word on the first stall cycle and muxes it onto the output.
module fetch_hold_buf
  import inst_fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] rdata_i,
  output logic [INSTR_W-1:0] instr_o
);
  logic               hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  always_comb begin
    hold_valid_d = clear_i ? 1'b0 : (hold_valid_q | capture_i);
    hold_instr_d = (capture_i & !hold_valid_q & !clear_i) ? rdata_i : hold_instr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end
  assign instr_o = hold_valid_q ? hold_instr_q : rdata_i;
endmodule

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: IF stage owning the fetch PC and driving a 1-cycle-latency inst_ram.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               inst_ram_ena,
  output logic [ADDR_W-1:0]  inst_ram_addr,
  input  logic [INSTR_W-1:0] inst_ram_rdata,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [INSTR_W-1:0] if_id_instr
);
  logic        issue, capture;
  logic [31:0] issued_pc;
  logic [31:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  always_comb begin
    issue       = !rst & (redirect_i | !stall_i);
    issued_pc   = redirect_i ? (redirect_pc_i & ALIGN_MASK) : pc_q;
    pc_d        = issue ? issued_pc + PC_INC : pc_q;
    rsp_pc_d    = issue ? issued_pc : rsp_pc_q;
    rsp_valid_d = issue | rsp_valid_q;
    capture     = stall_i & !redirect_i & rsp_valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  // Hold is cleared on any issue edge, so a released stall or a redirect never replays the held word.
  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .capture_i(capture),
    .clear_i  (issue),
    .rdata_i  (inst_ram_rdata),
    .instr_o  (if_id_instr)
  );
  assign inst_ram_ena  = issue;
  assign inst_ram_addr = issued_pc[ADDR_W+1:2];
  assign if_id_valid   = rsp_valid_q & !redirect_i;
  assign if_id_pc      = rsp_pc_q;
  assign if_id_pc4     = rsp_pc_q + PC_INC;
endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb_inst_fetch_stage: directed T1-T6 checks plus randomized run against a behavioural fetch model.
module tb_inst_fetch_stage;
  logic        clk = 0, rst = 1, stall = 0, redir = 0;
  logic [31:0] rpc = 0;
  logic        ena, valid;
  logic [9:0]  addr;
  logic [31:0] rdata = 0, pc, pc4, instr;
  logic [31:0] mem [1024];
  int          n_chk = 0, n_fail = 0;
  logic        m_ok = 0, m_valid = 0;
  logic [31:0] m_pc = 0, m_rsp_pc = 0;

  inst_fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
    .inst_ram_ena(ena), .inst_ram_addr(addr), .inst_ram_rdata(rdata),
    .if_id_valid(valid), .if_id_pc(pc), .if_id_pc4(pc4), .if_id_instr(instr)
  );

  always #5 clk = ~clk;

  // RAM drives garbage when not enabled so only a correct hold keeps the word stable.
  always @(posedge clk) rdata <= ena ? mem[addr] : $urandom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage presents, one cycle after issuing an address, the memory word at that PC.
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_valid = 0; m_pc = 0; m_rsp_pc = 0;
    end else if (redir || !stall) begin
      m_rsp_pc = redir ? {rpc[31:2], 2'b00} : m_pc;
      m_pc     = m_rsp_pc + 32'd4;
      m_valid  = 1;
    end
  end

  always @(negedge clk) if (m_ok) begin
    logic [31:0] tgt;
    tgt = redir ? {rpc[31:2], 2'b00} : m_pc;
    chk("ena", {31'b0, ena}, {31'b0, !rst && (redir || !stall)});
    if (!rst && (redir || !stall)) chk("addr", {22'b0, addr}, {22'b0, tgt[11:2]});
    chk("valid", {31'b0, valid}, {31'b0, m_valid && !redir});
    chk("pc", pc, m_rsp_pc);
    chk("pc4", pc4, m_rsp_pc + 32'd4);
    if (m_valid) chk("instr", instr, mem[m_rsp_pc[11:2]]);
  end

  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] p);
    rst = r; stall = s; redir = d; rpc = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[2] = 32'h2002_0005;
    drive(1, 0, 0, 0); tick(); tick();
    chk("rst_ena", {31'b0, ena}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    // T1
    drive(0, 0, 0, 0);
    chk("t1_addr0", {22'b0, addr}, 32'd0);
    chk("t1_valid0", {31'b0, valid}, 32'd0);
    tick();
    chk("t1_addr1", {22'b0, addr}, 32'd1);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_valid1", {31'b0, valid}, 32'd1);
    tick();
    chk("t1_addr2", {22'b0, addr}, 32'd2);
    chk("t1_pc4", pc, 32'h4);
    tick();
    chk("t1_pc8", pc, 32'h8);
    // T2
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ena", {31'b0, ena}, 32'd0);
      chk("t2_pc", pc, 32'h8);
      chk("t2_instr", instr, 32'h2002_0005);
      chk("t2_valid", {31'b0, valid}, 32'd1);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("t2_rel_addr", {22'b0, addr}, 32'd3);
    chk("t2_rel_instr", instr, 32'h2002_0005);
    tick();
    chk("t2_pcC", pc, 32'hC);
    tick();
    chk("t2_pc10", pc, 32'h10);
    // T3
    drive(0, 0, 1, 32'h40);
    chk("t3_valid", {31'b0, valid}, 32'd0);
    chk("t3_addr", {22'b0, addr}, 32'h10);
    tick();
    drive(0, 0, 0, 0);
    chk("t3_pc40", pc, 32'h40);
    tick();
    chk("t3_pc44", pc, 32'h44);
    // T4
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 1, 32'h83);
    chk("t4_ena", {31'b0, ena}, 32'd1);
    chk("t4_addr", {22'b0, addr}, 32'h20);
    tick();
    drive(0, 0, 0, 0);
    chk("t4_pc", pc, 32'h80);
    chk("t4_instr", instr, mem[32]);
    tick();
    // T5
    drive(0, 1, 0, 0); tick(); tick();
    drive(1, 1, 0, 0);
    chk("t5_ena", {31'b0, ena}, 32'd0);
    tick();
    chk("t5_valid", {31'b0, valid}, 32'd0);
    drive(0, 0, 0, 0);
    chk("t5_addr", {22'b0, addr}, 32'd0);
    tick();
    chk("t5_pc", pc, 32'h0);
    chk("t5_instr", instr, mem[0]);
    // T6
    drive(0, 0, 1, 32'hFFC);
    chk("t6_addr1023", {22'b0, addr}, 32'd1023);
    tick();
    drive(0, 0, 0, 0);
    chk("t6_addr0", {22'b0, addr}, 32'd0);
    chk("t6_pcFFC", pc, 32'hFFC);
    tick();
    chk("t6_pc1000", pc, 32'h1000);
    chk("t6_pc4", pc4, 32'h1004);
    chk("t6_instr", instr, mem[0]);
    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 32'h1FFF);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, p);
      tick();
    end
    drive(0, 0, 0, 0); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
